// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl
// Five-phase (fetch, decode, execute, memory, write-back) control unit for
// the extended datapath. A single memory port is shared between instruction
// fetch and data access, with a mem_ready completion handshake.
//
// Ports
//   clk, rst       : clock, synchronous active-high reset
//   opcode, funct  : instruction fields from the datapath IR
//   zero, overflow : ALU flags
//   mem_ready      : memory finishes the current read/write this cycle
//   ALU_Control    : 000 and, 001 or, 010 add, 110 sub, 111 slt
//   ALUSrc_B       : 0 register B, 1 sign-extended imm16
//   RegWrite, DatatoReg, RegDst, Jal : register file write controls
//   Branch         : PC source (00 PC+4, 01 branch target, 10 jump target)
//   PCWrite, IRWrite : PC / IR load strobes
//   MemRead, MemWrite, IorD : memory request and address select
//   instr_done     : pulse on the retiring cycle
//   exc_ovf, exc_ill : overflow-suppressed write / illegal instruction pulses
//   inst_count     : retired-instruction counter (wraps)
module multicycle_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             overflow,
  input  logic             mem_ready,
  output logic [2:0]       ALU_Control,
  output logic             ALUSrc_B,
  output logic             RegWrite,
  output logic [1:0]       DatatoReg,
  output logic [1:0]       Branch,
  output logic             Jal,
  output logic             RegDst,
  output logic             PCWrite,
  output logic             IRWrite,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IorD,
  output logic             instr_done,
  output logic             exc_ovf,
  output logic             exc_ill,
  output logic [CNT_W-1:0] inst_count
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_EXEC   = 4'd3,
    S_ALUWB  = 4'd4,
    S_MADDR  = 4'd5,
    S_MRD    = 4'd6,
    S_MWB    = 4'd7,
    S_MWR    = 4'd8,
    S_BR     = 4'd9,
    S_JMP    = 4'd10,
    S_ILL    = 4'd11
  } state_t;

  state_t           state_r;
  state_t           state_s;
  logic [5:0]       opcode_r;
  logic [5:0]       funct_r;
  logic [CNT_W-1:0] inst_count_r;
  logic [2:0]       alu_sel_s;
  logic             is_imm_s;
  logic             ovf_hit_s;
  logic             br_taken_s;

  // R-type funct codes this unit can execute
  function automatic logic funct_legal(input logic [5:0] fn);
    logic ok;
    case (fn)
      FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: ok = 1'b1;
      default:                               ok = 1'b0;
    endcase
    return ok;
  endfunction

  // ALU operation for an arithmetic/logic instruction
  function automatic logic [2:0] alu_op(input logic [5:0] op, input logic [5:0] fn);
    logic [2:0] sel;
    if (op == OP_ADDI) begin
      sel = ALU_ADD;
    end else if (op == OP_SLTI) begin
      sel = ALU_SLT;
    end else begin
      case (fn)
        FN_ADD:  sel = ALU_ADD;
        FN_SUB:  sel = ALU_SUB;
        FN_AND:  sel = ALU_AND;
        FN_OR:   sel = ALU_OR;
        FN_SLT:  sel = ALU_SLT;
        default: sel = ALU_AND;
      endcase
    end
    return sel;
  endfunction

  // Instructions whose signed overflow must suppress the register write
  function automatic logic traps_ovf(input logic [5:0] op, input logic [5:0] fn);
    logic t;
    if (op == OP_ADDI) begin
      t = 1'b1;
    end else if (op == OP_RTYPE) begin
      t = (fn == FN_ADD) || (fn == FN_SUB);
    end else begin
      t = 1'b0;
    end
    return t;
  endfunction

  assign alu_sel_s  = alu_op(opcode_r, funct_r);
  assign is_imm_s   = (opcode_r != OP_RTYPE);
  assign ovf_hit_s  = traps_ovf(opcode_r, funct_r) && overflow;
  // beq takes the branch on zero, bne on non-zero
  assign br_taken_s = (opcode_r == OP_BEQ) ? zero : !zero;
  assign inst_count = inst_count_r;

  // State register, decode-time instruction latch and retire counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= S_IDLE;
      opcode_r     <= 6'h00;
      funct_r      <= 6'h00;
      inst_count_r <= '0;
    end else begin
      state_r <= state_s;
      if (state_r == S_DECODE) begin
        opcode_r <= opcode;
        funct_r  <= funct;
      end
      if (instr_done) begin
        inst_count_r <= inst_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  // Next-state and control outputs
  always_comb begin
    state_s     = state_r;
    ALU_Control = 3'b000;
    ALUSrc_B    = 1'b0;
    RegWrite    = 1'b0;
    DatatoReg   = 2'b00;
    Branch      = 2'b00;
    Jal         = 1'b0;
    RegDst      = 1'b0;
    PCWrite     = 1'b0;
    IRWrite     = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IorD        = 1'b0;
    instr_done  = 1'b0;
    exc_ovf     = 1'b0;
    exc_ill     = 1'b0;
    case (state_r)
      S_IDLE: begin
        state_s = S_FETCH;
      end
      S_FETCH: begin
        MemRead = 1'b1;
        if (mem_ready) begin
          IRWrite = 1'b1;
          state_s = S_DECODE;
        end else begin
          state_s = S_FETCH;
        end
      end
      // The IR was just loaded, so dispatch on the live fields; they are
      // latched on this same edge for the remaining phases.
      S_DECODE: begin
        case (opcode)
          OP_RTYPE: begin
            if (funct_legal(funct)) begin
              state_s = S_EXEC;
            end else begin
              state_s = S_ILL;
            end
          end
          OP_ADDI, OP_SLTI: state_s = S_EXEC;
          OP_LW, OP_SW:     state_s = S_MADDR;
          OP_BEQ, OP_BNE:   state_s = S_BR;
          OP_J, OP_JAL:     state_s = S_JMP;
          default:          state_s = S_ILL;
        endcase
      end
      S_EXEC: begin
        ALU_Control = alu_sel_s;
        ALUSrc_B    = is_imm_s;
        state_s     = S_ALUWB;
      end
      S_ALUWB: begin
        ALU_Control = alu_sel_s;
        ALUSrc_B    = is_imm_s;
        RegDst      = !is_imm_s;
        PCWrite     = 1'b1;
        instr_done  = 1'b1;
        if (ovf_hit_s) begin
          exc_ovf = 1'b1;
        end else begin
          RegWrite = 1'b1;
        end
        state_s = S_FETCH;
      end
      S_MADDR: begin
        ALU_Control = ALU_ADD;
        ALUSrc_B    = 1'b1;
        if (opcode_r == OP_LW) begin
          state_s = S_MRD;
        end else begin
          state_s = S_MWR;
        end
      end
      S_MRD: begin
        ALU_Control = ALU_ADD;
        ALUSrc_B    = 1'b1;
        MemRead     = 1'b1;
        IorD        = 1'b1;
        if (mem_ready) begin
          state_s = S_MWB;
        end else begin
          state_s = S_MRD;
        end
      end
      S_MWB: begin
        RegWrite   = 1'b1;
        DatatoReg  = 2'b01;
        PCWrite    = 1'b1;
        instr_done = 1'b1;
        state_s    = S_FETCH;
      end
      S_MWR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
        if (mem_ready) begin
          PCWrite    = 1'b1;
          instr_done = 1'b1;
          state_s    = S_FETCH;
        end else begin
          state_s = S_MWR;
        end
      end
      S_BR: begin
        ALU_Control = ALU_SUB;
        PCWrite     = 1'b1;
        instr_done  = 1'b1;
        if (br_taken_s) begin
          Branch = 2'b01;
        end else begin
          Branch = 2'b00;
        end
        state_s = S_FETCH;
      end
      S_JMP: begin
        PCWrite    = 1'b1;
        Branch     = 2'b10;
        instr_done = 1'b1;
        if (opcode_r == OP_JAL) begin
          RegWrite  = 1'b1;
          Jal       = 1'b1;
          DatatoReg = 2'b10;
        end else begin
          RegWrite  = 1'b0;
        end
        state_s = S_FETCH;
      end
      S_ILL: begin
        exc_ill = 1'b1;
        PCWrite = 1'b1;
        state_s = S_FETCH;
      end
      default: begin
        state_s = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed testbench for multicycle_ctrl. Inputs change 1 time unit after a
// rising edge; outputs are compared on the falling edge of every cycle.
module tb_multicycle_ctrl;

  logic        clk;
  logic        rst;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic        zero;
  logic        overflow;
  logic        mem_ready;
  logic [2:0]  ALU_Control;
  logic        ALUSrc_B;
  logic        RegWrite;
  logic [1:0]  DatatoReg;
  logic [1:0]  Branch;
  logic        Jal;
  logic        RegDst;
  logic        PCWrite;
  logic        IRWrite;
  logic        MemRead;
  logic        MemWrite;
  logic        IorD;
  logic        instr_done;
  logic        exc_ovf;
  logic        exc_ill;
  logic [31:0] inst_count;
  logic [18:0] ctrl;

  int n_checks = 0;
  int n_errors = 0;

  multicycle_ctrl #(.CNT_W(32)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero),
    .overflow(overflow), .mem_ready(mem_ready), .ALU_Control(ALU_Control),
    .ALUSrc_B(ALUSrc_B), .RegWrite(RegWrite), .DatatoReg(DatatoReg),
    .Branch(Branch), .Jal(Jal), .RegDst(RegDst), .PCWrite(PCWrite),
    .IRWrite(IRWrite), .MemRead(MemRead), .MemWrite(MemWrite), .IorD(IorD),
    .instr_done(instr_done), .exc_ovf(exc_ovf), .exc_ill(exc_ill),
    .inst_count(inst_count)
  );

  assign ctrl = {ALU_Control, ALUSrc_B, RegWrite, DatatoReg, Branch, Jal, RegDst,
                 PCWrite, IRWrite, MemRead, MemWrite, IorD, instr_done, exc_ovf, exc_ill};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pack an expected control word in the same field order as ctrl
  function automatic logic [18:0] mk(
    input logic [2:0] alu, input logic sb, input logic rw, input logic [1:0] d2r,
    input logic [1:0] br, input logic jal, input logic rd, input logic pcw,
    input logic irw, input logic mr, input logic mw, input logic iord,
    input logic dn, input logic ov, input logic il);
    return {alu, sb, rw, d2r, br, jal, rd, pcw, irw, mr, mw, iord, dn, ov, il};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One cycle: compare control word and counter, then move past next edge
  task automatic cyc(input string tag, input logic [18:0] exp_ctrl, input logic [31:0] exp_cnt);
    @(negedge clk);
    check({tag, "_ctrl"}, {13'd0, ctrl}, {13'd0, exp_ctrl});
    check({tag, "_cnt"}, inst_count, exp_cnt);
    @(posedge clk);
    #1;
  endtask

  logic [18:0] Z, F_RDY, F_WAIT, EX_ADD, WB_ADD, WB_OVF, EX_SLTI, WB_SLTI;
  logic [18:0] MADDR, MRD, MWB, MWR_W, MWR_R, BR_T, BR_N, JAL, ILL;

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    Z       = 19'd0;
    F_RDY   = mk(3'b000, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    F_WAIT  = mk(3'b000, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    EX_ADD  = mk(3'b010, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    WB_ADD  = mk(3'b010, 1'b0, 1'b1, 2'b00, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    WB_OVF  = mk(3'b010, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    EX_SLTI = mk(3'b111, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    WB_SLTI = mk(3'b111, 1'b1, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    MADDR   = mk(3'b010, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    MRD     = mk(3'b010, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    MWB     = mk(3'b000, 1'b0, 1'b1, 2'b01, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    MWR_W   = mk(3'b000, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    MWR_R   = mk(3'b000, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    BR_T    = mk(3'b110, 1'b0, 1'b0, 2'b00, 2'b01, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    BR_N    = mk(3'b110, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    JAL     = mk(3'b000, 1'b0, 1'b1, 2'b10, 2'b10, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    ILL     = mk(3'b000, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    rst = 1'b1; opcode = 6'h00; funct = 6'h00; zero = 1'b0; overflow = 1'b0; mem_ready = 1'b1;
    @(posedge clk);
    #1;
    cyc("reset", Z, 32'd0);
    rst = 1'b0;
    cyc("idle", Z, 32'd0);

    // add: 4 cycles; IR fields disturbed after decode to prove the latch is used
    opcode = 6'h00; funct = 6'h20;
    cyc("add_fetch", F_RDY, 32'd0);
    cyc("add_dec", Z, 32'd0);
    opcode = 6'h2B; funct = 6'h00;
    cyc("add_exec", EX_ADD, 32'd0);
    cyc("add_wb", WB_ADD, 32'd0);

    // lw with 3 wait cycles in MRD: 8 cycles total
    opcode = 6'h23;
    cyc("lw_fetch", F_RDY, 32'd1);
    cyc("lw_dec", Z, 32'd1);
    cyc("lw_maddr", MADDR, 32'd1);
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) cyc("lw_mrd_wait", MRD, 32'd1);
    mem_ready = 1'b1;
    cyc("lw_mrd_rdy", MRD, 32'd1);
    cyc("lw_mwb", MWB, 32'd1);

    // beq taken then not taken
    opcode = 6'h04; zero = 1'b1;
    cyc("beq_t_fetch", F_RDY, 32'd2);
    cyc("beq_t_dec", Z, 32'd2);
    cyc("beq_t_br", BR_T, 32'd2);
    zero = 1'b0;
    cyc("beq_n_fetch", F_RDY, 32'd3);
    cyc("beq_n_dec", Z, 32'd3);
    cyc("beq_n_br", BR_N, 32'd3);

    // jal
    opcode = 6'h03;
    cyc("jal_fetch", F_RDY, 32'd4);
    cyc("jal_dec", Z, 32'd4);
    cyc("jal_jmp", JAL, 32'd4);

    // add with overflow: write suppressed, PC still advances
    opcode = 6'h00; funct = 6'h20;
    cyc("ovf_fetch", F_RDY, 32'd5);
    cyc("ovf_dec", Z, 32'd5);
    cyc("ovf_exec", EX_ADD, 32'd5);
    overflow = 1'b1;
    cyc("ovf_wb", WB_OVF, 32'd5);

    // slti ignores overflow
    opcode = 6'h0A; funct = 6'h00;
    cyc("slti_fetch", F_RDY, 32'd6);
    cyc("slti_dec", Z, 32'd6);
    cyc("slti_exec", EX_SLTI, 32'd6);
    cyc("slti_wb", WB_SLTI, 32'd6);
    overflow = 1'b0;

    // illegal opcode and illegal R-type funct: not counted
    opcode = 6'h3F;
    cyc("ill_op_fetch", F_RDY, 32'd7);
    cyc("ill_op_dec", Z, 32'd7);
    cyc("ill_op", ILL, 32'd7);
    opcode = 6'h00; funct = 6'h21;
    cyc("ill_fn_fetch", F_RDY, 32'd7);
    cyc("ill_fn_dec", Z, 32'd7);
    cyc("ill_fn", ILL, 32'd7);

    // sw zero-wait: 4 cycles
    opcode = 6'h2B;
    cyc("sw_fetch", F_RDY, 32'd7);
    cyc("sw_dec", Z, 32'd7);
    cyc("sw_maddr", MADDR, 32'd7);
    cyc("sw_mwr", MWR_R, 32'd7);

    // sw stalled in MWR, reset mid-wait
    cyc("sw2_fetch", F_RDY, 32'd8);
    cyc("sw2_dec", Z, 32'd8);
    cyc("sw2_maddr", MADDR, 32'd8);
    mem_ready = 1'b0;
    cyc("sw2_wait", MWR_W, 32'd8);
    rst = 1'b1;
    cyc("sw2_wait_rst", MWR_W, 32'd8);
    cyc("rst_mid", Z, 32'd0);
    rst = 1'b0;
    cyc("rst_idle", Z, 32'd0);
    cyc("rst_fetch_wait", F_WAIT, 32'd0);
    mem_ready = 1'b1;
    cyc("rst_fetch", F_RDY, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
